// File: rtl/td4_program_rom.sv
// td4_program_rom
//   16 x 8-bit program store feeding the TD4 core. Bytes are shifted in
//   from Tiny Tapeout pins while load=1 (one byte per wr_strobe rising edge).
//   Instructions are fetched by pc while load=0 after a load has happened.
//
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   load                  : async pin, 1 = load mode, 0 = run mode
//   wr_strobe, wr_data    : async write strobe, program byte {opcode,imm}
//   pc                    : fetch address from the core
//   opcode, immediate     : registered instruction fields (0/0 unless RUN)
//   fetch_valid           : outputs came from memory
//   wr_count, overflow    : bytes written this load (0..16), sticky overrun
//   running               : state is RUN
module td4_program_rom #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       wr_strobe,
  input  logic [7:0] wr_data,
  input  logic [3:0] pc,
  output logic [3:0] opcode,
  output logic [3:0] immediate,
  output logic       fetch_valid,
  output logic [4:0] wr_count,
  output logic       overflow,
  output logic       running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] load_sync;
  logic [SYNC_STAGES-1:0] str_sync;
  logic                   str_prev;
  logic                   load_s;
  logic                   str_s;
  logic                   str_rise;
  logic                   load_entry;
  logic                   wr_req;
  logic                   wr_en;

  logic [7:0] mem [16];

  // Pin synchronizers plus one extra flop of strobe history for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_sync <= '0;
      str_sync  <= '0;
      str_prev  <= 1'b0;
    end else begin
      load_sync <= {load_sync[SYNC_STAGES-2:0], load};
      str_sync  <= {str_sync[SYNC_STAGES-2:0], wr_strobe};
      str_prev  <= str_sync[SYNC_STAGES-1];
    end
  end

  assign load_s   = load_sync[SYNC_STAGES-1];
  assign str_s    = str_sync[SYNC_STAGES-1];
  assign str_rise = str_s & ~str_prev;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (load_s)  state_next = LOAD;
      LOAD:    if (!load_s) state_next = RUN;
      RUN:     if (load_s)  state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  assign running    = (state == RUN);
  assign load_entry = (state != LOAD) && (state_next == LOAD);
  // Writes key off the current state, so a strobe landing on the
  // LOAD->RUN edge still commits.
  assign wr_req     = (state == LOAD) && str_rise;
  assign wr_en      = wr_req && (wr_count < 5'd16);

  // Entry into LOAD and a write request are mutually exclusive: entry
  // requires state != LOAD, a write requires state == LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
      overflow <= 1'b0;
    end else if (load_entry) begin
      wr_count <= '0;
      overflow <= 1'b0;
    end else if (wr_en) begin
      wr_count <= wr_count + 5'd1;
    end else if (wr_req) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_count[3:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode      <= '0;
      immediate   <= '0;
      fetch_valid <= 1'b0;
    end else if (state == RUN) begin
      {opcode, immediate} <= mem[pc];
      fetch_valid         <= 1'b1;
    end else begin
      opcode      <= '0;
      immediate   <= '0;
      fetch_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_td4_program_rom.sv
module tb_td4_program_rom;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic       wr_strobe = 1'b0;
  logic [7:0] wr_data = '0;
  logic [3:0] pc = '0;
  logic [3:0] opcode;
  logic [3:0] immediate;
  logic       fetch_valid;
  logic [4:0] wr_count;
  logic       overflow;
  logic       running;

  int n_tests = 0;
  int n_fail  = 0;

  td4_program_rom #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .wr_strobe(wr_strobe),
    .wr_data(wr_data), .pc(pc), .opcode(opcode), .immediate(immediate),
    .fetch_valid(fetch_valid), .wr_count(wr_count), .overflow(overflow),
    .running(running)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Pins are seen by the design two edges after being sampled; the model
  // keeps a short history of sampled pin values to reproduce that delay.
  int   m_mode;          // 0 idle, 1 loading, 2 running
  byte  m_mem [16];
  int   m_cnt;
  bit   m_ovf;
  int   m_op, m_imm;
  bit   m_fv;
  bit   ld_hist [3];
  bit   st_hist [3];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0; m_cnt = 0; m_ovf = 0; m_op = 0; m_imm = 0; m_fv = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        for (int i = 0; i < 3; i++) begin ld_hist[i] = 0; st_hist[i] = 0; end
      end else begin
        bit seen_load, rise;
        int new_mode;
        seen_load = ld_hist[1];
        rise      = st_hist[1] && !st_hist[2];
        // fetch from pre-edge mode and memory
        if (m_mode == 2) begin
          m_op = int'(m_mem[pc][7:4]); m_imm = int'(m_mem[pc][3:0]); m_fv = 1;
        end else begin
          m_op = 0; m_imm = 0; m_fv = 0;
        end
        if (m_mode == 1 && rise) begin
          if (m_cnt < 16) begin
            m_mem[m_cnt] = byte'(wr_data);
            m_cnt++;
          end else begin
            m_ovf = 1;
          end
        end
        new_mode = m_mode;
        if (seen_load) new_mode = 1;
        else if (m_mode == 1) new_mode = 2;
        if (new_mode == 1 && m_mode != 1) begin
          m_cnt = 0; m_ovf = 0;
        end
        m_mode = new_mode;
        ld_hist[2] = ld_hist[1]; ld_hist[1] = ld_hist[0]; ld_hist[0] = load;
        st_hist[2] = st_hist[1]; st_hist[1] = st_hist[0]; st_hist[0] = wr_strobe;
      end
    end
  end

  // One compare process: every cycle, mid-period.
  initial begin
    forever begin
      @(negedge clk);
      check("opcode",      int'(opcode),      m_op);
      check("immediate",   int'(immediate),   m_imm);
      check("fetch_valid", int'(fetch_valid), int'(m_fv));
      check("wr_count",    int'(wr_count),    m_cnt);
      check("overflow",    int'(overflow),    int'(m_ovf));
      check("running",     int'(running),     int'(m_mode == 2));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic set_load(input bit v);
    load = v;
    cycles(4);
  endtask

  task automatic strobe(input logic [7:0] d);
    wr_data = d;
    wr_strobe = 1'b1;
    cycles(4);
    wr_strobe = 1'b0;
    cycles(3);
  endtask

  task automatic fetch_lit(input string name, input logic [3:0] a,
                           input int eop, input int eimm, input int efv);
    pc = a;
    cycles(1);
    check({name, "_op"},  int'(opcode),      eop);
    check({name, "_imm"}, int'(immediate),   eimm);
    check({name, "_fv"},  int'(fetch_valid), efv);
  endtask

  initial begin
    cycles(2);
    check("rst_op", int'(opcode), 0);
    check("rst_fv", int'(fetch_valid), 0);
    rst_n = 1'b1;
    cycles(5);
    check("idle_fv", int'(fetch_valid), 0);

    // basic load/run
    set_load(1'b1);
    strobe(8'h35); strobe(8'h72); strobe(8'h01);
    check("basic_cnt", int'(wr_count), 3);
    set_load(1'b0);
    check("basic_running", int'(running), 1);
    fetch_lit("pc0", 4'd0, 3, 5, 1);
    fetch_lit("pc1", 4'd1, 7, 2, 1);
    fetch_lit("pc2", 4'd2, 0, 1, 1);
    fetch_lit("pc3", 4'd3, 0, 0, 1);

    // strobe latency and hold, then overflow
    set_load(1'b1);
    check("reload_cnt", int'(wr_count), 0);
    wr_data = 8'hC4;
    wr_strobe = 1'b1;
    cycles(1); check("lat_e1", int'(wr_count), 0);
    cycles(1); check("lat_e2", int'(wr_count), 0);
    cycles(1); check("lat_e3", int'(wr_count), 1);
    cycles(10); check("hold_cnt", int'(wr_count), 1);
    wr_strobe = 1'b0;
    cycles(3);
    for (int i = 1; i < 17; i++) strobe(8'h10 + 8'(i));
    check("ovf_cnt", int'(wr_count), 16);
    check("ovf_flag", int'(overflow), 1);
    set_load(1'b0);
    fetch_lit("ovf_mem0", 4'd0, 4'hC, 4'h4, 1);
    fetch_lit("ovf_mem15", 4'd15, 4'h1, 4'hF, 1);
    set_load(1'b1);
    check("ovf_clr", int'(overflow), 0);
    check("cnt_clr", int'(wr_count), 0);

    // reload mid-run
    set_load(1'b0);
    set_load(1'b1);
    check("load_fv", int'(fetch_valid), 0);
    strobe(8'hA9);
    set_load(1'b0);
    fetch_lit("rl_pc0", 4'd0, 4'hA, 4'h9, 1);
    fetch_lit("rl_pc1", 4'd1, 4'h1, 4'h1, 1);

    // write coincident with LOAD->RUN edge
    set_load(1'b1);
    wr_data = 8'h5E; wr_strobe = 1'b1; load = 1'b0;
    cycles(4);
    check("coin_run", int'(running), 1);
    check("coin_cnt", int'(wr_count), 1);
    wr_strobe = 1'b0;
    cycles(3);
    fetch_lit("coin_pc0", 4'd0, 4'h5, 4'hE, 1);
    // strobe during RUN is ignored
    strobe(8'hFF);
    check("run_str_cnt", int'(wr_count), 1);
    fetch_lit("run_str_pc1", 4'd1, 4'h1, 4'h1, 1);

    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) load = ~load;
      if ($urandom_range(0, 2) == 0) wr_strobe = ~wr_strobe;
      wr_data = 8'($urandom);
      pc = 4'($urandom);
      cycles(1);
    end

    // reset mid-load with strobes active
    load = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_strobe = ~wr_strobe; wr_data = 8'($urandom); cycles(1);
    end
    #3 rst_n = 1'b0;
    #1;
    check("amid_rst_op", int'(opcode), 0);
    check("amid_rst_cnt", int'(wr_count), 0);
    check("amid_rst_run", int'(running), 0);
    load = 1'b0; wr_strobe = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pc = 4'($urandom);
      cycles(1);
      check("post_rst_fv", int'(fetch_valid), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/td4_program_rom.md
Name: td4_program_rom

Overview:
- Instruction source directly upstream of the TD4 CPU core: holds a 16-entry x 8-bit program and drives the core's opcode/immediate inputs from the core's pc output.
- Programmed serially from Tiny Tapeout input pins using a strobe with a level-controlled load mode, then switched to run mode for fetching.
- All pin inputs pass through synchronizers; the block is fully synchronous to clk apart from the reset.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the load/wr_strobe synchronizers (minimum 2); pin-to-action latency is SYNC_STAGES+1 clk edges.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
load  input  1  async pin; 1 = load mode, 0 = run mode.
wr_strobe  input  1  async pin; each rising edge writes one byte while in LOAD.
wr_data  input  8  program byte; [7:4] = opcode, [3:0] = immediate; must be held stable from the wr_strobe rise until the write edge.
pc  input  4  fetch address from the CPU core.
opcode  output  4  registered instruction opcode to the core.
immediate  output  4  registered instruction immediate to the core.
fetch_valid  output  1  1 when opcode/immediate came from memory (RUN).
wr_count  output  5  bytes written since entering LOAD (0..16).
overflow  output  1  sticky; set by a write attempt when wr_count==16.
running  output  1  1 while state==RUN.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all 16 memory entries = 8'h00; opcode=0, immediate=0, fetch_valid=0, wr_count=0, overflow=0, running=0; synchronizer and edge-history flops cleared to 0. Reset mid-load or mid-run discards everything.
- Synchronizers: load and wr_strobe each pass through SYNC_STAGES flops. load_s = last stage. str_s = last stage; str_prev = str_s delayed 1 clk; str_rise = str_s & ~str_prev.
- States: IDLE, LOAD, RUN (next-state evaluated from load_s):
  - IDLE -> LOAD when load_s=1.
  - LOAD -> RUN when load_s=0.
  - RUN -> LOAD when load_s=1.
  - IDLE stays IDLE while load_s=0. The program stays all-zero and is never fetched until a LOAD/RUN sequence occurs.
- Entry to LOAD (edge where state becomes LOAD): wr_count<=0, overflow<=0. Memory contents are not cleared; unwritten entries keep old values.
- Write: on an edge where the current state==LOAD and str_rise=1:
  - If wr_count<16: mem[wr_count[3:0]] <= wr_data, wr_count <= wr_count+1.
  - Else: memory untouched and overflow<=1.
  - The write uses the current state, so a write coincident with the LOAD->RUN transition edge is committed.
  - A held-high strobe produces exactly one write.
  - str_rise during IDLE or RUN is ignored.
- Pin latency: with default SYNC_STAGES=2, a wr_strobe rise (setup met) is written at the 3rd clk edge; a load change changes state at the 3rd edge.
- Fetch: every edge:
  - If state==RUN (current): {opcode,immediate} <= mem[pc], fetch_valid<=1.
  - Else: both <= 0, fetch_valid<=0.
  - Latency is 1 clk from pc to outputs. The first cycle after entering RUN still shows 0/0 (NOP: ADD A,0).
  - pc is used as a full 4-bit address with no wrap logic needed.
- running = (state==RUN), combinational from the state register.
- wr_count saturates at 16 and never wraps. overflow holds until the next LOAD entry or reset.

Test Plan:
- Reset: assert rst_n=0 mid-operation with load=1 and strobes active -> all outputs 0, state IDLE; after release with load=0, opcode/immediate/fetch_valid remain 0 indefinitely.
- Basic load/run: load=1, strobes with bytes 8'h35, 8'h72, 8'h01; load=0; drive pc=0,1,2 -> opcode/immediate = 3/5, 7/2, 0/1, each one clk after pc; fetch_valid=1; wr_count=3; pc=3 -> 0/0.
- Strobe latency and hold: raise wr_strobe and hold it high 10 clks -> exactly one write, at the 3rd edge after the rise; wr_count increments once.
- Overflow: 17 strobes in LOAD -> wr_count=16, overflow=1, mem[0] still equals the first byte; re-entering LOAD clears overflow and wr_count.
- Reload mid-run: in RUN, raise load and write 8'hA9 -> outputs drop to 0/0 with fetch_valid=0 while loading; back in RUN with pc=0 -> A/9, and pc=1 returns the old entry.
- Coincident events: time the 3rd-edge write of a strobe to the same edge as the LOAD->RUN transition -> byte is committed; a strobe rising during RUN causes no write and no wr_count change.
